// File: rtl/fetch_prefetch.sv
// Fetch stage with an in-order prefetch queue between instruction memory and decode.
// Optional FETCH_STATS_EN adds saturating popped/dropped instruction counters.
module fetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      contMux4,
    input  logic [XLEN-1:0] brPC,
    input  logic [XLEN-1:0] intExtend,
    input  logic [XLEN-1:0] intJAL,
    input  logic [XLEN-1:0] intJALR,
    output logic            memReqValid,
    input  logic            memReqReady,
    output logic [XLEN-1:0] memAddr,
    input  logic            memRspValid,
    input  logic [XLEN-1:0] memRspData,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outINPUT,
    output logic [XLEN-1:0] dataPC,
    output logic [XLEN-1:0] dataPC4
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     statFetched,
    output logic [31:0]     statDropped
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetchPC_r;
    logic [XLEN-1:0] qInstr_r [DEPTH];
    logic [XLEN-1:0] qPC_r    [DEPTH];
    logic [PW-1:0]   qHead_r, qTail_r;
    logic [CW-1:0]   qCount_r;
    logic [XLEN-1:0] aPC_r    [DEPTH];
    logic [PW-1:0]   aHead_r, aTail_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   discard_r;

    logic            redirect_s;
    logic            credit_s;
    logic            reqFire_s;
    logic            rspFire_s;
    logic            rspDrop_s;
    logic            push_s;
    logic            pop_s;
    logic [XLEN-1:0] targetRaw_s;
    logic [XLEN-1:0] targetAligned_s;
    logic [CW-1:0]   outstandingNext_s;

    // Handshake decode, credit and redirect target selection.
    always_comb begin
        redirect_s  = (contMux4 != 2'd0);
        credit_s    = (({1'b0, qCount_r} + {1'b0, outstanding_r}) < (CW+1)'(DEPTH));
        memReqValid = reset && !redirect_s && credit_s;
        memAddr     = fetchPC_r;
        reqFire_s   = memReqValid && memReqReady;
        // A response with nothing outstanding is a protocol error and is ignored.
        rspFire_s   = memRspValid && (outstanding_r != {CW{1'b0}});
        rspDrop_s   = rspFire_s && (redirect_s || (discard_r != {CW{1'b0}}));
        push_s      = rspFire_s && !rspDrop_s;
        outValid    = (qCount_r != {CW{1'b0}});
        pop_s       = outValid && outReady;
        if (outValid) begin
            outINPUT = qInstr_r[qHead_r];
            dataPC   = qPC_r[qHead_r];
            dataPC4  = qPC_r[qHead_r] + XLEN'(4);
        end else begin
            outINPUT = '0;
            dataPC   = '0;
            dataPC4  = '0;
        end
        case (contMux4)
            2'd1:    targetRaw_s = intJAL;
            2'd2:    targetRaw_s = brPC + intExtend;
            2'd3:    targetRaw_s = intJALR & ~{{(XLEN-1){1'b0}}, 1'b1};
            default: targetRaw_s = fetchPC_r;
        endcase
        targetAligned_s   = targetRaw_s & ~{{(XLEN-2){1'b0}}, 2'b11};
        outstandingNext_s = outstanding_r + CW'(reqFire_s) - CW'(rspFire_s);
    end

    // Fetch PC, request tag FIFO and in-flight / discard accounting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetchPC_r     <= RESET_PC;
            aHead_r       <= '0;
            aTail_r       <= '0;
            outstanding_r <= '0;
            discard_r     <= '0;
            for (int i = 0; i < DEPTH; i++) aPC_r[i] <= '0;
        end else if (redirect_s) begin
            // Everything still in flight belongs to the old path.
            fetchPC_r     <= targetAligned_s;
            aHead_r       <= '0;
            aTail_r       <= '0;
            outstanding_r <= outstandingNext_s;
            discard_r     <= outstandingNext_s;
        end else begin
            if (reqFire_s) begin
                fetchPC_r      <= fetchPC_r + XLEN'(4);
                aPC_r[aTail_r] <= fetchPC_r;
                aTail_r        <= aTail_r + PW'(1);
            end
            if (push_s) begin
                aHead_r <= aHead_r + PW'(1);
            end
            if (rspDrop_s) begin
                discard_r <= discard_r - CW'(1);
            end
            outstanding_r <= outstandingNext_s;
        end
    end

    // Instruction queue storage and pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            qHead_r  <= '0;
            qTail_r  <= '0;
            qCount_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qInstr_r[i] <= '0;
                qPC_r[i]    <= '0;
            end
        end else if (redirect_s) begin
            qHead_r  <= '0;
            qTail_r  <= '0;
            qCount_r <= '0;
        end else begin
            if (push_s) begin
                qInstr_r[qTail_r] <= memRspData;
                qPC_r[qTail_r]    <= aPC_r[aHead_r];
                qTail_r           <= qTail_r + PW'(1);
            end
            if (pop_s) begin
                qHead_r <= qHead_r + PW'(1);
            end
            qCount_r <= qCount_r + CW'(push_s) - CW'(pop_s);
        end
    end

`ifdef FETCH_STATS_EN
    function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [31:0] droppedInc_s;

    // Dropped count: discarded responses plus entries flushed by a redirect.
    always_comb begin
        droppedInc_s = 32'(rspDrop_s);
        if (redirect_s) begin
            droppedInc_s = droppedInc_s + 32'(qCount_r) - 32'(pop_s);
        end else begin
            droppedInc_s = droppedInc_s;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            statFetched <= 32'd0;
            statDropped <= 32'd0;
        end else begin
            statFetched <= satAdd(statFetched, 32'(pop_s));
            statDropped <= satAdd(statDropped, droppedInc_s);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a fixed-latency in-order memory model.
module tb_fetch_prefetch;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int SLOTS = 4096;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      contMux4 = 2'd0;
    logic [XLEN-1:0] brPC = '0, intExtend = '0, intJAL = '0, intJALR = '0;
    logic            memReqValid, memReqReady = 1'b1;
    logic [XLEN-1:0] memAddr;
    logic            memRspValid = 1'b0;
    logic [XLEN-1:0] memRspData = '0;
    logic            outValid, outReady = 1'b0;
    logic [XLEN-1:0] outINPUT, dataPC, dataPC4;
`ifdef FETCH_STATS_EN
    logic [31:0]     statFetched, statDropped;
`endif

    always #5 clock = ~clock;

    fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .contMux4(contMux4), .brPC(brPC),
        .intExtend(intExtend), .intJAL(intJAL), .intJALR(intJALR),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memAddr(memAddr),
        .memRspValid(memRspValid), .memRspData(memRspData),
        .outValid(outValid), .outReady(outReady), .outINPUT(outINPUT),
        .dataPC(dataPC), .dataPC4(dataPC4)
`ifdef FETCH_STATS_EN
        , .statFetched(statFetched), .statDropped(statDropped)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } pop_t;

    typedef struct {
        int          lat;
        int          pre;
        logic [1:0]  mux;
        logic [31:0] brPC;
        logic [31:0] ext;
        logic [31:0] jal;
        logic [31:0] jalr;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    logic [31:0] reqLog[$];
    pop_t        popLog[$];
    logic        rspV [SLOTS];
    logic [31:0] rspD [SLOTS];
    int          cycleNo;
    int          lat;
    int          nChecks = 0;
    int          nFails  = 0;
    vec_t        vecs[6];

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] reqAt(input int i);
        return (reqLog.size() > i) ? reqLog[i] : 32'hXXXX_XXXX;
    endfunction

    function automatic pop_t popAt(input int i);
        pop_t p;
        p = '{32'hXXXX_XXXX, 32'hXXXX_XXXX, 32'hXXXX_XXXX};
        if (popLog.size() > i) p = popLog[i];
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge; models the memory.
    task automatic tick();
        memRspValid = rspV[cycleNo % SLOTS];
        memRspData  = rspD[cycleNo % SLOTS];
        #1;
        if (memReqValid && memReqReady) begin
            reqLog.push_back(memAddr);
            rspV[(cycleNo + lat) % SLOTS] = 1'b1;
            rspD[(cycleNo + lat) % SLOTS] = instrOf(memAddr);
        end
        if (outValid && outReady) popLog.push_back(pop_t'{outINPUT, dataPC, dataPC4});
        @(posedge clock);
        @(negedge clock);
        rspV[cycleNo % SLOTS] = 1'b0;
        cycleNo++;
    endtask

    task automatic doReset();
        reset       = 1'b0;
        contMux4    = 2'd0;
        memRspValid = 1'b0;
        outReady    = 1'b0;
        memReqReady = 1'b1;
        for (int i = 0; i < SLOTS; i++) rspV[i] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset   = 1'b1;
        cycleNo = 0;
        reqLog.delete();
        popLog.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int   firstPop;
        pop_t p;

        vecs[0] = '{3, 3, 2'd1, 32'h0000_0200, 32'h0000_0040, 32'h0000_000C, 32'h0000_0301, 32'h0000_000C, 32'h0000_0010};
        vecs[1] = '{1, 4, 2'd2, 32'h0000_0020, 32'h0000_000A, 32'h0000_0500, 32'h0000_0601, 32'h0000_0028, 32'h0000_002C};
        vecs[2] = '{1, 5, 2'd3, 32'h0000_0040, 32'h0000_0008, 32'h0000_0700, 32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[3] = '{1, 3, 2'd1, 32'h0000_0080, 32'h0000_0004, 32'hFFFF_FFFC, 32'h0000_0901, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{2, 6, 2'd2, 32'h0000_0100, 32'hFFFF_FFF8, 32'h0000_0A00, 32'h0000_0B01, 32'h0000_00F8, 32'h0000_00FC};
        vecs[5] = '{1, 2, 2'd3, 32'h0000_0180, 32'h0000_0010, 32'h0000_0C00, 32'h0000_0007, 32'h0000_0004, 32'h0000_0008};
        for (int i = 0; i < SLOTS; i++) begin
            rspV[i] = 1'b0;
            rspD[i] = 32'd0;
        end

        // Reset state, first addresses and steady-state throughput.
        @(negedge clock);
        #1;
        check("rstReqValid", 32'(memReqValid), 32'd0);
        check("rstOutValid", 32'(outValid), 32'd0);
        check("rstOutInput", outINPUT, 32'd0);
        check("rstDataPC", dataPC, 32'd0);
        check("rstDataPC4", dataPC4, 32'd0);
        @(negedge clock);
        reset = 1'b1; cycleNo = 0; lat = 1; outReady = 1'b1;
        repeat (3) tick();
        check("seqAddr0", reqAt(0), 32'h0);
        check("seqAddr1", reqAt(1), 32'h4);
        check("seqAddr2", reqAt(2), 32'h8);
        repeat (12) tick();
        check("throughput", 32'(popLog.size()), 32'd13);
        for (int i = 0; i < 4; i++) begin
            p = popAt(i);
            check("seqPopPC", p.pc, 32'(4 * i));
            check("seqPopPC4", p.pc4, 32'(4 * i + 4));
            check("seqPopInstr", p.instr, instrOf(32'(4 * i)));
        end

        // Backpressure: queue fills to DEPTH, then drains in order.
        doReset();
        lat = 1;
        repeat (10) tick();
        check("bpReqCount", 32'(reqLog.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("bpReqAddr", reqAt(i), 32'(4 * i));
        check("bpReqValidLow", 32'(memReqValid), 32'd0);
        check("bpOutValid", 32'(outValid), 32'd1);
        outReady = 1'b1;
        reqLog.delete();
        popLog.delete();
        repeat (8) tick();
        for (int i = 0; i < 4; i++) check("bpPopPC", popAt(i).pc, 32'(4 * i));
        check("bpResume", reqAt(0), 32'h10);

        // Redirect vectors: target select, alignment, wrap and in-flight discard.
        for (int v = 0; v < 6; v++) begin
            doReset();
            lat = vecs[v].lat;
            outReady = 1'b1;
            repeat (vecs[v].pre) tick();
            contMux4 = vecs[v].mux; brPC = vecs[v].brPC; intExtend = vecs[v].ext;
            intJAL = vecs[v].jal; intJALR = vecs[v].jalr;
            reqLog.delete();
            tick();
            check("redirNoReq", 32'(reqLog.size()), 32'd0);
            contMux4 = 2'd0;
            reqLog.delete();
            popLog.delete();
            firstPop = -1;
            for (int c = 0; c < 40 && popLog.size() < 2; c++) begin
                tick();
                if (firstPop < 0 && popLog.size() > 0) firstPop = c;
            end
            check("redirAddr0", reqAt(0), vecs[v].exp0);
            check("redirAddr1", reqAt(1), vecs[v].exp1);
            p = popAt(0);
            check("redirPopPC", p.pc, vecs[v].exp0);
            check("redirPopPC4", p.pc4, vecs[v].exp0 + 32'd4);
            check("redirPopInstr", p.instr, instrOf(vecs[v].exp0));
            p = popAt(1);
            check("redirPop1PC", p.pc, vecs[v].exp1);
            check("redirPop1Instr", p.instr, instrOf(vecs[v].exp1));
            check("redirLatency", 32'(firstPop), 32'(vecs[v].lat + 1));
        end

`ifdef FETCH_STATS_EN
        // Statistics: two discarded responses, five pops, then asynchronous reset.
        doReset();
        lat = 3;
        outReady = 1'b1;
        repeat (2) tick();
        contMux4 = 2'd1;
        intJAL = 32'h0000_0040;
        tick();
        contMux4 = 2'd0;
        popLog.delete();
        for (int c = 0; c < 40 && popLog.size() < 5; c++) tick();
        outReady = 1'b0;
        check("statFetched", statFetched, 32'd5);
        check("statDropped", statDropped, 32'd2);
        check("statPopPC", popAt(0).pc, 32'h40);
        outReady = 1'b1;
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        check("rstStatFetched", statFetched, 32'd0);
        check("rstStatDropped", statDropped, 32'd0);
        check("rstMidOutValid", 32'(outValid), 32'd0);
        check("rstMidReqValid", 32'(memReqValid), 32'd0);
        check("rstMidDataPC", dataPC, 32'd0);
        @(negedge clock);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised fetch stage with an in-order prefetch queue between instruction memory and decode. Holds the fetch PC, issues word requests to a variable-latency instruction memory, and buffers up to DEPTH instructions with their PC and PC+4 for decode under a valid/ready handshake. Supports four next-PC sources (sequential, JAL, PC-relative branch, JALR). On redirect it flushes the queue and discards responses still in flight.

## Interface
- XLEN, 32: width of PC, immediates and instruction word.
- DEPTH, 4: queue entries; also the maximum number of outstanding memory requests. Power of two, 2 to 16.
- RESET_PC, 0: fetch PC after reset.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- contMux4  in  2  redirect select: 0 none (sequential), 1 JAL, 2 branch, 3 JALR.
- brPC  in  XLEN  PC of the redirecting instruction.
- intExtend  in  XLEN  sign-extended branch offset.
- intJAL  in  XLEN  absolute JAL target.
- intJALR  in  XLEN  JALR target before LSB clear.
- memReqValid  out  1  request valid.
- memReqReady  in  1  memory accepts request.
- memAddr  out  XLEN  request address, word aligned.
- memRspValid  in  1  response valid; responses return in request order.
- memRspData  in  XLEN  instruction word.
- outValid  out  1  queue head valid.
- outReady  in  1  decode accepts head.
- outINPUT  out  XLEN  head instruction.
- dataPC  out  XLEN  head PC.
- dataPC4  out  XLEN  head PC + 4.

## Operation
- **Reset:**
  - fetchPC = RESET_PC.
  - Queue empty; outstanding = 0; discard = 0.
  - memReqValid = 0, outValid = 0.
  - outINPUT, dataPC and dataPC4 read 0.
- **Credit:** memReqValid = 1 when (occupancy + outstanding) < DEPTH and contMux4 = 0.
- **Request issue:** on memReqValid && memReqReady: memAddr = fetchPC, fetchPC += 4, outstanding += 1.
- **Response:**
  - If discard > 0: drop the response and decrement discard.
  - Otherwise: push {memRspData, PC}, where the PC tag comes from an internal address FIFO of depth DEPTH.
- **Pop:** on outValid && outReady, advance the head.
- **Redirect (contMux4 ≠ 0), taken at the clock edge:**
  - Target selection:
    - 1: intJAL
    - 2: brPC + intExtend
    - 3: intJALR & ~1
  - fetchPC = target & ~3 (two LSBs forced to 0).
  - Queue and address FIFO cleared.
  - discard = outstanding at that edge. A response arriving in the redirect cycle is dropped and is not counted in discard.
  - A pop handshake in the same cycle completes normally.
- **Arithmetic:** all PC arithmetic is modulo 2^XLEN. 0xFFFFFFFC + 4 wraps to 0.
- **Full queue:** the credit rule guarantees a response always has space. Asserting memRspValid with outstanding = 0 is a protocol error; that response is ignored.
- **Simultaneous push and pop on a full queue:** legal; occupancy is unchanged.

## Timing
- Cycle 0 after reset release: memReqValid = 1 with memAddr = RESET_PC.
- Latency from response to outValid: 1 cycle (registered queue).
- Steady-state throughput with single-cycle memory: 1 instruction per cycle.
- Redirect cycle: no request issued. The first request to the target is in the next cycle.
- First valid instruction on the new path: at least 2 cycles after the redirect edge with single-cycle memory.
- Reset asserted mid-operation: immediate return to reset values. Responses already in flight in memory are the memory's responsibility; after reset the block assumes outstanding = 0.

## Configuration
- FETCH_STATS_EN:
  - Defined: adds outputs statFetched (32 bits, count of instructions popped) and statDropped (32 bits, count of responses discarded or queue entries flushed). Both counters saturate at all-ones and reset to 0.
  - Undefined: ports and logic are absent.

## Test plan
- **Reset:** reset held low with RESET_PC = 0 → memReqValid = 0 and outValid = 0. After release, memAddr = 0, then 4, then 8 on consecutive cycles; dataPC4 = dataPC + 4 on each pop.
- **Backpressure:** outReady = 0, single-cycle memory, DEPTH = 4 → exactly 4 requests (0x0 to 0xC), then memReqValid = 0. Releasing outReady yields 4 pops in order, then fetching resumes at 0x10.
- **JAL with in-flight responses:** memory latency 3, contMux4 = 1, intJAL = 12 while 3 requests are outstanding → those 3 responses are dropped and the next memAddr = 0xC.
- **Branch:** brPC = 0x20, intExtend = 10, contMux4 = 2 → next memAddr = 0x28 (0x2A aligned).
- **JALR and wrap-around:** contMux4 = 3, intJALR = 0x103 → memAddr = 0x100. A separate JAL to 0xFFFFFFFC → the following address is 0x0.
- **Mid-operation reset, with FETCH_STATS_EN defined:** after 5 pops and 2 drops, statFetched = 5 and statDropped = 2. Asserting reset mid-stream clears both counters and the queue in the same cycle.
